pipe_frame_accumulator: RTL and testbench
=========================================

Name: pipe_frame_accumulator

Overview:
- Downstream consumer of the two-lane multiply pipeline. Takes its 32-bit result stream C and sums every LEN consecutive results into one frame sum, forming a dot product of length LEN.
- Completed sums pass through a small output FIFO with a valid/ready handshake, so the pipeline keeps streaming while the sink stalls.
- The block sits between the multiply pipeline and the result writer.

Parameters:
- LEN, 4, number of input beats summed per frame (>=2)
- ACC_W, 40, accumulator and output width in bits (>=33), two's complement
- FIFO_DEPTH, 2, output FIFO entries; must be a power of 2, >=2

Ports:
- clk  input  1  clock; everything updates on posedge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid pipeline result
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  32  pipeline result C, signed two's complement
- clear  input  1  discard the partial frame in progress
- out_valid  output  1  out_sum and out_ovf hold a completed frame
- out_ready  input  1  sink accepts the frame this cycle
- out_sum  output  ACC_W  frame sum at the FIFO head
- out_ovf  output  1  signed overflow occurred during this frame

Behaviour:
- Reset (synchronous, high at posedge):
  - Clears acc=0, cnt=0, frame_ovf=0 and empties the FIFO.
  - After that edge: out_valid=0, out_sum=0, out_ovf=0.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after.
  - Reset mid-frame or with the FIFO occupied discards everything; no partial frame is emitted.
- Accept: a beat is accepted when in_valid && in_ready at posedge.
  - in_ready = !reset && (fifo_count != FIFO_DEPTH). It depends only on registers and reset, with no combinational path from out_ready.
- Accumulation, per accepted beat:
  - s = acc + sign_extend(in_data, ACC_W), wrapping modulo 2^ACC_W.
  - ovf_step is set when both operands share a sign and the sign of s differs.
- Non-final beat (cnt != LEN-1): acc<=s, cnt<=cnt+1, frame_ovf<=frame_ovf|ovf_step.
- Final beat (cnt == LEN-1):
  - Pushes {s, frame_ovf|ovf_step} into the FIFO.
  - Sets acc<=0, cnt<=0, frame_ovf<=0.
- Latency: with the FIFO empty, a final beat accepted at edge k gives out_valid=1 with that sum after edge k. This is one cycle, with no bypass.
- Output:
  - out_valid = (fifo_count != 0).
  - out_sum and out_ovf show the head entry, and read 0 when the FIFO is empty.
  - The head is popped when out_valid && out_ready.
  - Entries leave in push order and stay stable while out_valid && !out_ready.
- Simultaneous push and pop: allowed in any state where the push is legal. fifo_count is unchanged and the pointers advance by one each.
  - When full, a pop in a cycle does not raise in_ready in that same cycle; it rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with a count register of width clog2(FIFO_DEPTH)+1.
- clear, synchronous:
  - Sets acc=0, cnt=0, frame_ovf=0. The FIFO is untouched.
  - If clear coincides with an accepted beat, clear wins: the beat is consumed and discarded, and nothing is pushed even when it would have been the final beat.
- reset has priority over clear and over every handshake.
- in_data is ignored whenever in_valid=0.
- No latches. One always block per register group. The FIFO is registers, not RAM.

Test Plan (LEN=4, ACC_W=40, FIFO_DEPTH=2 unless stated):
- Reset, then beats 1,2,3,4 on consecutive cycles with out_ready=1 -> one cycle after the 4th beat, out_valid=1, out_sum=10, out_ovf=0 for exactly one cycle.
- Beats 0xFFFFFFFF x4 (each -1) -> out_sum=40'hFF_FFFF_FFFC (-4), out_ovf=0.
- out_ready=0, stream 12 beats of value 1 with in_valid held high:
  - in_ready falls after the 8th beat is accepted; out_sum=4 is held stable.
  - Raise out_ready -> pops of 4, 4, then after the 3rd frame completes, 4.
  - No beat is lost and fifo_count never exceeds 2.
- ACC_W=33 instance, beats 0x7FFFFFFF x4 -> out_ovf=1. The next frame 1,1,1,1 gives out_sum=4, out_ovf=0 (overflow does not carry across frames).
- Beats 5,6, then clear asserted together with a valid beat 9, then beats 1,1,1,1 -> a single output out_sum=4. Also cover clear on the 4th beat -> no output for that frame.
- Fill the FIFO with one frame plus 2 beats of the next, assert reset for 1 cycle -> next cycle out_valid=0, out_sum=0. A fresh frame 2,2,2,2 then gives out_sum=8.

Source files
------------

// File: rtl/pipe_frame_accumulator.sv
// rtl/pipe_frame_accumulator.sv - sums every LEN pipeline results into a frame sum behind a small output FIFO
module pipe_frame_accumulator #(
    parameter int LEN        = 4,
    parameter int ACC_W      = 40,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CW = $clog2(LEN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);
    localparam logic [PW:0]   FULL = (PW + 1)'(FIFO_DEPTH);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] s;
    logic [CW-1:0]    cnt;
    logic             frame_ovf;
    logic             ovf_step;
    logic             accept;
    logic             push;
    logic             pop;

    logic [ACC_W-1:0] fifo_sum [FIFO_DEPTH];
    logic             fifo_ovf [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    assign ext      = {{(ACC_W - 32){in_data[31]}}, in_data};
    assign s        = acc + ext;
    assign ovf_step = (acc[ACC_W-1] == ext[ACC_W-1]) && (s[ACC_W-1] != acc[ACC_W-1]);

    // in_ready looks only at registered count so out_ready never reaches it combinationally
    assign in_ready  = !reset && (count != FULL);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !clear && (cnt == LAST);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_sum   = out_valid ? fifo_sum[rd_ptr] : '0;
    assign out_ovf   = out_valid ? fifo_ovf[rd_ptr] : 1'b0;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc       <= '0;
            cnt       <= '0;
            frame_ovf <= 1'b0;
        end else if (accept) begin
            if (cnt == LAST) begin
                acc       <= '0;
                cnt       <= '0;
                frame_ovf <= 1'b0;
            end else begin
                acc       <= s;
                cnt       <= cnt + CW'(1);
                frame_ovf <= frame_ovf | ovf_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read side is gated by count
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_sum[wr_ptr] <= s;
            fifo_ovf[wr_ptr] <= frame_ovf | ovf_step;
        end
    end

endmodule

// File: tb/tb_pipe_frame_accumulator.sv
// tb/tb_pipe_frame_accumulator.sv - directed and random checks of pipe_frame_accumulator at ACC_W 40 and 33
module tb_pipe_frame_accumulator;

    localparam int LEN = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        clear;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [39:0] out_sum_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [32:0] out_sum_b;

    int n_cmp = 0;
    int n_err = 0;

    longint macc [2];
    bit     movf [2];
    int     mcnt;
    int     n_acc;
    longint qs0 [$];
    longint qs1 [$];
    bit     qo0 [$];
    bit     qo1 [$];

    pipe_frame_accumulator #(.LEN(LEN), .ACC_W(40), .FIFO_DEPTH(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .clear(clear), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(out_sum_a), .out_ovf(out_ovf_a)
    );

    pipe_frame_accumulator #(.LEN(LEN), .ACC_W(33), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .clear(clear), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_ovf(out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint wrapw(input longint v, input int w);
        longint r;
        r = v & ((longint'(1) << w) - 1);
        if (((r >> (w - 1)) & 1) != 0) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic bit outrange(input longint v, input int w);
        return (v > ((longint'(1) << (w - 1)) - 1)) || (v < -(longint'(1) << (w - 1)));
    endfunction

    function automatic logic [63:0] low_bits(input longint v, input int w);
        return logic'(64'(v)) ? 64'(v) & ((64'd1 << w) - 1) : 64'(v) & ((64'd1 << w) - 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        macc[0] = 0; macc[1] = 0;
        movf[0] = 0; movf[1] = 0;
        mcnt = 0;
    endtask

    task automatic cyc(input bit v, input logic [31:0] d, input bit clr, input bit ordy, input bit rst);
        bit     exp_ir;
        longint x;
        longint t;
        int     w;
        in_valid  = v;
        in_data   = d;
        clear     = clr;
        out_ready = ordy;
        reset     = rst;
        #1;
        exp_ir = !rst && (qs0.size() != 2);
        check("in_ready_40", 64'(in_ready_a), 64'(exp_ir));
        check("in_ready_33", 64'(in_ready_b), 64'(exp_ir));
        @(posedge clk);
        if (rst) begin
            model_zero();
            qs0.delete(); qs1.delete(); qo0.delete(); qo1.delete();
        end else begin
            if (qs0.size() != 0 && ordy) begin
                void'(qs0.pop_front()); void'(qo0.pop_front());
                void'(qs1.pop_front()); void'(qo1.pop_front());
            end
            if (v && exp_ir) begin
                n_acc++;
                if (clr) begin
                    model_zero();
                end else begin
                    x = $signed(d);
                    for (int k = 0; k < 2; k++) begin
                        w = (k == 0) ? 40 : 33;
                        t = macc[k] + x;
                        movf[k] = movf[k] | outrange(t, w);
                        macc[k] = wrapw(t, w);
                    end
                    if (mcnt == LEN - 1) begin
                        qs0.push_back(macc[0]); qo0.push_back(movf[0]);
                        qs1.push_back(macc[1]); qo1.push_back(movf[1]);
                        model_zero();
                    end else begin
                        mcnt++;
                    end
                end
            end else if (clr) begin
                model_zero();
            end
        end
        #1;
        check("out_valid_40", 64'(out_valid_a), 64'(qs0.size() != 0));
        check("out_sum_40", 64'(out_sum_a), (qs0.size() != 0) ? low_bits(qs0[0], 40) : 64'd0);
        check("out_ovf_40", 64'(out_ovf_a), (qo0.size() != 0) ? 64'(qo0[0]) : 64'd0);
        check("out_valid_33", 64'(out_valid_b), 64'(qs1.size() != 0));
        check("out_sum_33", 64'(out_sum_b), (qs1.size() != 0) ? low_bits(qs1[0], 33) : 64'd0);
        check("out_ovf_33", 64'(out_ovf_b), (qo1.size() != 0) ? 64'(qo1[0]) : 64'd0);
    endtask

    initial begin
        int start;
        logic [31:0] d;
        model_zero();
        n_acc = 0;

        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);

        for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0, 1, 0);
        check("dir_sum10", 64'(out_sum_a), 64'd10);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) cyc(1, 32'hFFFF_FFFF, 0, 1, 0);
        check("dir_sum_neg4", 64'(out_sum_a), 64'h00FF_FFFF_FFFC);
        cyc(0, 0, 0, 1, 0);

        start = n_acc;
        for (int i = 0; i < 12; i++) cyc(1, 32'd1, 0, 0, 0);
        check("stall_held_sum", 64'(out_sum_a), 64'd4);
        check("stall_accepted", 64'(n_acc - start), 64'd8);
        for (int i = 0; i < 60 && (n_acc - start) < 12; i++) cyc(1, 32'd1, 0, 1, 0);
        check("stall_all_beats", 64'(n_acc - start), 64'd12);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) cyc(1, 32'h7FFF_FFFF, 0, 0, 0);
        check("ovf33_set", 64'(out_ovf_b), 64'd1);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'd1, 0, 1, 0);
        check("ovf33_cleared", 64'(out_ovf_b), 64'd0);
        cyc(0, 0, 0, 1, 0);

        cyc(1, 32'd5, 0, 1, 0);
        cyc(1, 32'd6, 0, 1, 0);
        cyc(1, 32'd9, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'd1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'd1, 0, 1, 0);
        cyc(1, 32'd1, 1, 1, 0);
        check("clear_last_no_out", 64'(out_valid_a), 64'd0);
        cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 6; i++) cyc(1, 32'd3, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        check("reset_mid_valid", 64'(out_valid_a), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1, 32'd2, 0, 1, 0);
        check("post_reset_sum8", 64'(out_sum_a), 64'd8);
        cyc(0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20)) - 32'd10;
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0,
                $urandom_range(0, 4) < 3, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
